// File: rtl/exec_cond_unit_pkg.sv
// Shared types and constants for the execute-stage condition unit.
// Condition codes, NZCV bit positions and FlagWrite bit positions.
package exec_cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/exec_cond_unit_cond_check.sv
// Combinational evaluation of a 4-bit condition field against NZCV.
// Shared by the execute unit and its reference model.
module cond_check
    import exec_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        cond_ex = 1'b1;
        unique case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = !z;
            CS: cond_ex = c;
            CC: cond_ex = !c;
            MI: cond_ex = n;
            PL: cond_ex = !n;
            VS: cond_ex = v;
            VC: cond_ex = !v;
            HI: cond_ex = c & !z;
            LS: cond_ex = !c | z;
            GE: cond_ex = (n == v);
            LT: cond_ex = (n != v);
            GT: cond_ex = !z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            NV: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_cond_unit.sv
// Execute-stage flag register, condition gating and flush/stall requests.
// Define PC_WRITE_STALL_EN to add the pending PC-write counter and StallF path.
module exec_cond_unit
    import exec_cond_unit_pkg::*;
#(
    parameter int PEND_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWriteE,
    input  logic [3:0] ALUFlags,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       BranchE,
    output logic       PCSrcGE,
    output logic       RegWriteGE,
    output logic       MemWriteGE,
    output logic       BranchTakenE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       StallF,
    output logic [3:0] FlagsQ
);

    logic cond_ex;
    logic suppress;
    logic ok;

    cond_check u_cond_check (
        .cond    (CondE),
        .flags   (FlagsQ),
        .cond_ex (cond_ex)
    );

    assign ok           = cond_ex & !suppress;
    assign RegWriteGE   = RegWriteE & ok;
    assign MemWriteGE   = MemWriteE & ok;
    assign PCSrcGE      = PCSrcE & ok & !BranchE;
    assign BranchTakenE = BranchE & ok;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FlagsQ <= 4'b0000;
        end else begin
            if (ok && FlagWriteE[FW_NZ]) begin
                FlagsQ[N_IDX] <= ALUFlags[N_IDX];
                FlagsQ[Z_IDX] <= ALUFlags[Z_IDX];
            end
            if (ok && FlagWriteE[FW_CV]) begin
                FlagsQ[C_IDX] <= ALUFlags[C_IDX];
                FlagsQ[V_IDX] <= ALUFlags[V_IDX];
            end
        end
    end

`ifdef PC_WRITE_STALL_EN
    logic [1:0] pend_cnt;
    logic       pend;
    logic       pend_flush_e;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_cnt <= 2'd0;
        end else if (PCSrcGE) begin
            pend_cnt <= 2'(PEND_CYCLES);
        end else if (pend_cnt != 2'd0) begin
            pend_cnt <= pend_cnt - 2'd1;
        end
    end

    // D/E clear lands one cycle before the stall releases
    generate
        if (PEND_CYCLES == 1) begin : g_fe_one
            assign pend_flush_e = PCSrcGE;
        end else begin : g_fe_many
            assign pend_flush_e = (pend_cnt == 2'd2);
        end
    endgenerate

    assign pend     = (pend_cnt != 2'd0);
    assign suppress = pend;
    assign StallF   = PCSrcGE | pend;
    assign FlushD   = BranchTakenE | PCSrcGE | pend;
    assign FlushE   = BranchTakenE | pend_flush_e;
`else
    logic unused_pend;

    assign unused_pend = PEND_CYCLES[0];
    assign suppress    = 1'b0;
    assign StallF      = 1'b0;
    assign FlushD      = BranchTakenE | PCSrcGE;
    assign FlushE      = BranchTakenE | PCSrcGE;
`endif

endmodule
